opcode_decode_stage: RTL

- Pipelined decode stage for the control path: accepts a 3-bit opcode and emits the matching 8-bit one-hot function code (opcode n -> bit n set).
- Sits between the opcode issue logic and the function units.
- Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so upstream can stream one op per cycle while downstream stalls.
- Keeps a count of delivered ops for pipeline-control debug.

---
 rtl/opcode_decode_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/opcode_decode_stage.sv
// Decode stage: 3-bit opcode -> one-hot function code, 1-cycle latency, 2-entry skid so in_ready is registered.
// Optional OPC_PARITY_EN adds even-parity checking on the input; bad-parity ops are dropped and flagged.
module opcode_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
`ifdef OPC_PARITY_EN
  input  logic             in_parity,
  output logic             parity_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_func_code,
  output logic [2:0]       out_opcode,
  output logic [CNT_W-1:0] op_count
);

  // bit0 = main register valid, bit1 = skid register valid
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] main_op;
  logic [2:0] skid_op;
  logic       accept;
  logic       transfer;
  logic       load;

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

`ifdef OPC_PARITY_EN
  logic par_bad;
  assign par_bad = ^{in_opcode, in_parity};
  assign load    = accept & ~par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= accept & par_bad;
    end
  end
`else
  assign load = accept;
`endif

  // in_ready comes straight from the skid-valid flop, never from out_ready
  assign in_ready      = ~state[1];
  assign out_valid     = state[0];
  assign out_opcode    = main_op;
  assign out_func_code = out_valid ? (8'b1 << main_op) : 8'h00;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load) state_nxt = ST_ONE;
      ST_ONE: begin
        if (load && !transfer)      state_nxt = ST_TWO;
        else if (!load && transfer) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (transfer) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      main_op  <= 3'b000;
      skid_op  <= 3'b000;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_EMPTY: if (load) main_op <= in_opcode;
        ST_ONE: begin
          if (load && transfer)  main_op <= in_opcode;
          if (load && !transfer) skid_op <= in_opcode;
        end
        ST_TWO:   if (transfer) main_op <= skid_op;
        default:  ;
      endcase
      // a transfer in the flush cycle has already left the stage, so it counts
      if (transfer) op_count <= op_count + 1'b1;
    end
  end

endmodule
